mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory request port between the instruction cache and the data cache.
- Accepts one transaction at a time from either cache. Arbitrates round-robin on a tie.
- Forwards the winning request to memory with registered outputs, holds it stable until memory answers, then returns read data and a one-cycle ready pulse to the winner.
- Keeps per-requester completed-transaction counters for performance debug.

Parameters:
- ADDR_W, 32, width of request address.
- DATA_W, 32, width of read and write data.
- CNT_W, 16, width of each completed-transaction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ic_req_addr  in  ADDR_W  I-cache request address.
- ic_req_valid  in  1  I-cache request valid; held high until ic_req_ready.
- ic_req_wr  in  1  I-cache write flag (1=write).
- ic_wr_data  in  DATA_W  I-cache write data.
- ic_rd_data  out  DATA_W  read data returned to I-cache.
- ic_req_ready  out  1  one-cycle completion pulse to I-cache.
- dc_req_addr, dc_req_valid, dc_req_wr, dc_wr_data, dc_rd_data, dc_req_ready: same as the ic_* ports, for the D-cache.
- mem_req_addr  out  ADDR_W  address to memory.
- mem_wr_data  out  DATA_W  write data to memory.
- mem_req_valid  out  1  memory request valid.
- mem_req_wr  out  1  memory write flag.
- mem_req_data  in  DATA_W  memory read data, valid while mem_req_ready=1.
- mem_req_ready  in  1  memory completion.
- ic_done_cnt  out  CNT_W  completed I-cache transactions.
- dc_done_cnt  out  CNT_W  completed D-cache transactions.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge) drives the following:
  - state=IDLE; last_grant=DC, so the I-cache wins the first tie.
  - All mem_* outputs = 0.
  - ic/dc_req_ready = 0; ic/dc_rd_data = 0; both counters = 0.
- States: IDLE, BUSY_IC, BUSY_DC, DONE.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - Neither valid: stay in IDLE.
  - On grant:
    - Latch the winner's addr, wr and wr_data into mem_req_addr, mem_req_wr and mem_wr_data.
    - Set mem_req_valid=1 and last_grant=winner.
    - Go to BUSY_IC or BUSY_DC.
- BUSY_x:
  - mem_req_addr, mem_req_wr, mem_wr_data and mem_req_valid stay constant while mem_req_ready=0; no timeout.
  - Requester input changes are ignored (already latched).
  - When mem_req_ready=1:
    - mem_req_valid<=0.
    - x_rd_data<=mem_req_data. For writes, x_rd_data is still loaded with mem_req_data; the content is don't-care.
    - x_req_ready<=1; x_done_cnt<=x_done_cnt+1, wrapping modulo 2^CNT_W.
    - Go to DONE.
- DONE:
  - x_req_ready is high for exactly this one cycle; it deasserts on the next edge.
  - No grant is made in DONE, which guarantees the requester has dropped valid before resampling.
  - Next state is IDLE.
- x_rd_data holds its value until the next completion for x.
- mem_req_ready is ignored in IDLE and DONE.
- Latency: x_req_valid first sampled high in IDLE at edge t.
  - mem_req_valid=1 after edge t.
  - Memory returns mem_req_ready=1 sampled at edge t+k (k≥1): x_req_ready=1 after edge t+k, state IDLE after edge t+k+1.
  - A pending request is granted at edge t+k+2 at the earliest.
  - Minimum turnaround: 3 cycles per transaction.
- Fairness: under continuous requests from both caches, grants strictly alternate IC, DC, IC, DC…
- Requester drops valid during BUSY (protocol violation): the transaction still completes, and the ready pulse and counter increment still occur.
- Reset mid-operation: the transaction is abandoned immediately (mem_req_valid=0 after the reset edge); memory must tolerate this.
- Simultaneous reset and mem_req_ready: reset wins; no ready pulse, no counter increment.
- The other requester's outputs never change during a transaction.

Test Plan:
- IC read only:
  - Stimulus: ic_req_addr=0x0000_1040, ic_req_valid=1, ic_req_wr=0; memory asserts ready 2 cycles after valid with data 0xDEAD_BEEF.
  - Required: mem_req_addr=0x1040 and mem_req_wr=0 one cycle after valid is sampled; ic_req_ready pulses for exactly 1 cycle with ic_rd_data=0xDEAD_BEEF; ic_done_cnt=1; dc_* outputs unchanged.
- Tie after reset:
  - Stimulus: IC (addr 0x100) and DC (addr 0x200) both valid in the same cycle.
  - Required: 0x100 is issued first, then 0x200 with no IC re-grant; last_grant=DC at end.
- Round-robin under saturation:
  - Stimulus: both caches re-raise valid immediately after each ready, for 6 transactions; memory ready delay k=1.
  - Required: order IC, DC, IC, DC, IC, DC; 3-cycle spacing between mem_req_valid rises; both counters=3.
- DC write:
  - Stimulus: dc_req_wr=1, addr=0x0000_0080, dc_wr_data=0x1234_5678; memory stalls 5 cycles.
  - Required: mem_req_wr=1 and mem_wr_data=0x1234_5678 held constant for all 5 stall cycles; dc_req_ready pulses once.
- Reset mid-operation:
  - Stimulus: assert rst while in BUSY_IC with mem_req_ready=1 in the same cycle.
  - Required: mem_req_valid=0 and ic_req_ready=0 after the edge; ic_done_cnt=0; the next IC request is served normally.
- Counter wrap:
  - Stimulus: CNT_W=4; run 17 IC transactions.
  - Required: ic_done_cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory request port between the I-cache
// and the D-cache. One transaction in flight at a time, round-robin on ties,
// every output registered, per-requester completion counters for debug.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_valid,
  input  logic              ic_req_wr,
  input  logic [DATA_W-1:0] ic_wr_data,
  output logic [DATA_W-1:0] ic_rd_data,
  output logic              ic_req_ready,
  // D-cache side
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_valid,
  input  logic              dc_req_wr,
  input  logic [DATA_W-1:0] dc_wr_data,
  output logic [DATA_W-1:0] dc_rd_data,
  output logic              dc_req_ready,
  // Memory side
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_req_valid,
  output logic              mem_req_wr,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  // Performance counters
  output logic [CNT_W-1:0]  ic_done_cnt,
  output logic [CNT_W-1:0]  dc_done_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_IC,
    ST_BUSY_DC,
    ST_DONE
  } state_e;

  typedef enum logic {
    GNT_IC,
    GNT_DC
  } grant_e;

  state_e              state_q,         state_d;
  grant_e              last_grant_q,    last_grant_d;
  logic [ADDR_W-1:0]   mem_req_addr_q,  mem_req_addr_d;
  logic [DATA_W-1:0]   mem_wr_data_q,   mem_wr_data_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                mem_req_wr_q,    mem_req_wr_d;
  logic [DATA_W-1:0]   ic_rd_data_q,    ic_rd_data_d;
  logic                ic_req_ready_q,  ic_req_ready_d;
  logic [DATA_W-1:0]   dc_rd_data_q,    dc_rd_data_d;
  logic                dc_req_ready_q,  dc_req_ready_d;
  logic [CNT_W-1:0]    ic_done_cnt_q,   ic_done_cnt_d;
  logic [CNT_W-1:0]    dc_done_cnt_q,   dc_done_cnt_d;
  logic                grant_ic,        grant_dc;

  // Next-state and output computation for the arbitration FSM.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_wr_data_d   = mem_wr_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_wr_d    = mem_req_wr_q;
    ic_rd_data_d    = ic_rd_data_q;
    dc_rd_data_d    = dc_rd_data_q;
    ic_req_ready_d  = 1'b0;
    dc_req_ready_d  = 1'b0;
    ic_done_cnt_d   = ic_done_cnt_q;
    dc_done_cnt_d   = dc_done_cnt_q;

    // On a tie the requester that did not win last time takes the port.
    grant_ic = ic_req_valid && (!dc_req_valid || (last_grant_q == GNT_DC));
    grant_dc = dc_req_valid && !grant_ic;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_ic) begin
          mem_req_addr_d  = ic_req_addr;
          mem_wr_data_d   = ic_wr_data;
          mem_req_wr_d    = ic_req_wr;
          mem_req_valid_d = 1'b1;
          last_grant_d    = GNT_IC;
          state_d         = ST_BUSY_IC;
        end else if (grant_dc) begin
          mem_req_addr_d  = dc_req_addr;
          mem_wr_data_d   = dc_wr_data;
          mem_req_wr_d    = dc_req_wr;
          mem_req_valid_d = 1'b1;
          last_grant_d    = GNT_DC;
          state_d         = ST_BUSY_DC;
        end
      end

      // Request fields are already latched; requester inputs are ignored
      // until memory answers, however long that takes.
      ST_BUSY_IC: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          ic_rd_data_d    = mem_req_data;
          ic_req_ready_d  = 1'b1;
          ic_done_cnt_d   = ic_done_cnt_q + CNT_W'(1);
          state_d         = ST_DONE;
        end
      end

      ST_BUSY_DC: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          dc_rd_data_d    = mem_req_data;
          dc_req_ready_d  = 1'b1;
          dc_done_cnt_d   = dc_done_cnt_q + CNT_W'(1);
          state_d         = ST_DONE;
        end
      end

      // The ready pulse is visible during this cycle; no grant is made so
      // the finished requester has a cycle to drop its valid.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any
  // transaction in flight and takes priority over a same-cycle completion.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= GNT_DC;
      mem_req_addr_q  <= '0;
      mem_wr_data_q   <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_wr_q    <= 1'b0;
      ic_rd_data_q    <= '0;
      ic_req_ready_q  <= 1'b0;
      dc_rd_data_q    <= '0;
      dc_req_ready_q  <= 1'b0;
      ic_done_cnt_q   <= '0;
      dc_done_cnt_q   <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_wr_q    <= mem_req_wr_d;
      ic_rd_data_q    <= ic_rd_data_d;
      ic_req_ready_q  <= ic_req_ready_d;
      dc_rd_data_q    <= dc_rd_data_d;
      dc_req_ready_q  <= dc_req_ready_d;
      ic_done_cnt_q   <= ic_done_cnt_d;
      dc_done_cnt_q   <= dc_done_cnt_d;
    end
  end

  assign mem_req_addr  = mem_req_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_wr    = mem_req_wr_q;
  assign ic_rd_data    = ic_rd_data_q;
  assign ic_req_ready  = ic_req_ready_q;
  assign dc_rd_data    = dc_rd_data_q;
  assign dc_req_ready  = dc_req_ready_q;
  assign ic_done_cnt   = ic_done_cnt_q;
  assign dc_done_cnt   = dc_done_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a per-cycle vector table for
// single requests, ties and ignored inputs, plus hand-written sequences for
// write stalls, reset mid-operation, saturation fairness and counter wrap.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [31:0] IC_WD = 32'h1111_0000;
  localparam logic [31:0] DC_WD = 32'h2222_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] ic_req_addr = '0;
  logic              ic_req_valid = 1'b0;
  logic              ic_req_wr = 1'b0;
  logic [DATA_W-1:0] ic_wr_data = IC_WD;
  logic [DATA_W-1:0] ic_rd_data;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] dc_req_addr = '0;
  logic              dc_req_valid = 1'b0;
  logic              dc_req_wr = 1'b0;
  logic [DATA_W-1:0] dc_wr_data = DC_WD;
  logic [DATA_W-1:0] dc_rd_data;
  logic              dc_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_req_valid;
  logic              mem_req_wr;
  logic [DATA_W-1:0] mem_req_data = '0;
  logic              mem_req_ready = 1'b0;
  logic [CNT_W-1:0]  ic_done_cnt;
  logic [CNT_W-1:0]  dc_done_cnt;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_req_addr  (ic_req_addr),
    .ic_req_valid (ic_req_valid),
    .ic_req_wr    (ic_req_wr),
    .ic_wr_data   (ic_wr_data),
    .ic_rd_data   (ic_rd_data),
    .ic_req_ready (ic_req_ready),
    .dc_req_addr  (dc_req_addr),
    .dc_req_valid (dc_req_valid),
    .dc_req_wr    (dc_req_wr),
    .dc_wr_data   (dc_wr_data),
    .dc_rd_data   (dc_rd_data),
    .dc_req_ready (dc_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_wr   (mem_req_wr),
    .mem_req_data (mem_req_data),
    .mem_req_ready(mem_req_ready),
    .ic_done_cnt  (ic_done_cnt),
    .dc_done_cnt  (dc_done_cnt)
  );

  always #5 clk = ~clk;

  // One cycle: inputs set at a falling edge, outputs sampled at the next one.
  typedef struct {
    logic [31:0] rst, ic_v, ic_a, dc_v, dc_a, m_rdy, m_data;
    logic [31:0] e_mv, e_ma, e_mw, e_mwd, e_icr, e_icd, e_dcr, e_dcd, e_icc, e_dcc;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_g;
    logic [31:0] g_addr[6];
    int          g_cyc[6];
    logic        prev_mv;

    //              rst ic_v ic_a    dc_v dc_a   m_rdy m_data         e_mv e_ma    e_mw e_mwd  e_icr e_icd        e_dcr e_dcd        e_icc e_dcc
    vecs[0]  = '{0, 1, 'h1040, 0, 0,     0, 0,            1, 'h1040, 0, IC_WD, 0, 0,           0, 0,           0, 0};
    vecs[1]  = '{0, 1, 'h1040, 0, 0,     0, 0,            1, 'h1040, 0, IC_WD, 0, 0,           0, 0,           0, 0};
    vecs[2]  = '{0, 1, 'h1040, 0, 0,     1, 'hDEADBEEF,   0, 'h1040, 0, IC_WD, 1, 'hDEADBEEF,  0, 0,           1, 0};
    vecs[3]  = '{0, 0, 0,      0, 0,     0, 0,            0, 'h1040, 0, IC_WD, 0, 'hDEADBEEF,  0, 0,           1, 0};
    vecs[4]  = '{0, 0, 0,      0, 0,     1, 'h99999999,   0, 'h1040, 0, IC_WD, 0, 'hDEADBEEF,  0, 0,           1, 0};
    vecs[5]  = '{1, 0, 0,      0, 0,     0, 0,            0, 0,      0, 0,     0, 0,           0, 0,           0, 0};
    vecs[6]  = '{0, 1, 'h100,  1, 'h200, 0, 0,            1, 'h100,  0, IC_WD, 0, 0,           0, 0,           0, 0};
    vecs[7]  = '{0, 1, 'h100,  1, 'h200, 1, 'hAAAA0001,   0, 'h100,  0, IC_WD, 1, 'hAAAA0001,  0, 0,           1, 0};
    vecs[8]  = '{0, 0, 0,      1, 'h200, 1, 'h55555555,   0, 'h100,  0, IC_WD, 0, 'hAAAA0001,  0, 0,           1, 0};
    vecs[9]  = '{0, 1, 'h100,  1, 'h200, 0, 0,            1, 'h200,  0, DC_WD, 0, 'hAAAA0001,  0, 0,           1, 0};
    vecs[10] = '{0, 1, 'h100,  1, 'h200, 1, 'hBBBB0002,   0, 'h200,  0, DC_WD, 0, 'hAAAA0001,  1, 'hBBBB0002,  1, 1};
    vecs[11] = '{0, 1, 'h100,  0, 0,     0, 0,            0, 'h200,  0, DC_WD, 0, 'hAAAA0001,  0, 'hBBBB0002,  1, 1};
    vecs[12] = '{0, 1, 'h100,  0, 0,     0, 0,            1, 'h100,  0, IC_WD, 0, 'hAAAA0001,  0, 'hBBBB0002,  1, 1};
    vecs[13] = '{0, 0, 0,      0, 0,     1, 'hCCCC0003,   0, 'h100,  0, IC_WD, 1, 'hCCCC0003,  0, 'hBBBB0002,  2, 1};
    vecs[14] = '{0, 0, 0,      0, 0,     0, 0,            0, 'h100,  0, IC_WD, 0, 'hCCCC0003,  0, 'hBBBB0002,  2, 1};

    // Reset state.
    @(negedge clk);
    tick();
    check("rst mem_req_valid", 32'(mem_req_valid), 0);
    check("rst mem_req_addr",  mem_req_addr, 0);
    check("rst mem_req_wr",    32'(mem_req_wr), 0);
    check("rst mem_wr_data",   mem_wr_data, 0);
    check("rst ic_req_ready",  32'(ic_req_ready), 0);
    check("rst dc_req_ready",  32'(dc_req_ready), 0);
    check("rst ic_rd_data",    ic_rd_data, 0);
    check("rst dc_rd_data",    dc_rd_data, 0);
    check("rst ic_done_cnt",   32'(ic_done_cnt), 0);
    check("rst dc_done_cnt",   32'(dc_done_cnt), 0);
    rst = 1'b0;

    // Vector table: IC read, ignored mem_req_ready, tie after reset,
    // alternation on the next tie, valid dropped during BUSY.
    for (int i = 0; i < NV; i++) begin
      rst           = vecs[i].rst[0];
      ic_req_valid  = vecs[i].ic_v[0];
      ic_req_addr   = vecs[i].ic_a;
      dc_req_valid  = vecs[i].dc_v[0];
      dc_req_addr   = vecs[i].dc_a;
      mem_req_ready = vecs[i].m_rdy[0];
      mem_req_data  = vecs[i].m_data;
      tick();
      check($sformatf("v%0d mem_req_valid", i), 32'(mem_req_valid), vecs[i].e_mv);
      check($sformatf("v%0d mem_req_addr", i),  mem_req_addr,       vecs[i].e_ma);
      check($sformatf("v%0d mem_req_wr", i),    32'(mem_req_wr),    vecs[i].e_mw);
      check($sformatf("v%0d mem_wr_data", i),   mem_wr_data,        vecs[i].e_mwd);
      check($sformatf("v%0d ic_req_ready", i),  32'(ic_req_ready),  vecs[i].e_icr);
      check($sformatf("v%0d ic_rd_data", i),    ic_rd_data,         vecs[i].e_icd);
      check($sformatf("v%0d dc_req_ready", i),  32'(dc_req_ready),  vecs[i].e_dcr);
      check($sformatf("v%0d dc_rd_data", i),    dc_rd_data,         vecs[i].e_dcd);
      check($sformatf("v%0d ic_done_cnt", i),   32'(ic_done_cnt),   vecs[i].e_icc);
      check($sformatf("v%0d dc_done_cnt", i),   32'(dc_done_cnt),   vecs[i].e_dcc);
    end
    rst = 1'b0;
    mem_req_ready = 1'b0;

    // DC write with a 5-cycle memory stall; request inputs wiggle meanwhile.
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b1;
    dc_req_wr    = 1'b1;
    dc_req_addr  = 32'h0000_0080;
    dc_wr_data   = 32'h1234_5678;
    tick();
    check("dcw grant valid", 32'(mem_req_valid), 1);
    check("dcw grant addr",  mem_req_addr, 32'h0000_0080);
    check("dcw grant wr",    32'(mem_req_wr), 1);
    check("dcw grant data",  mem_wr_data, 32'h1234_5678);
    dc_req_addr = 32'hFFFF_0000;
    dc_wr_data  = 32'hFFFF_FFFF;
    dc_req_wr   = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("dcw stall%0d valid", s), 32'(mem_req_valid), 1);
      check($sformatf("dcw stall%0d addr", s),  mem_req_addr, 32'h0000_0080);
      check($sformatf("dcw stall%0d wr", s),    32'(mem_req_wr), 1);
      check($sformatf("dcw stall%0d data", s),  mem_wr_data, 32'h1234_5678);
      check($sformatf("dcw stall%0d ready", s), 32'(dc_req_ready), 0);
    end
    mem_req_ready = 1'b1;
    mem_req_data  = 32'h0BAD_0000;
    tick();
    check("dcw done ready",  32'(dc_req_ready), 1);
    check("dcw done cnt",    32'(dc_done_cnt), 2);
    check("dcw done valid",  32'(mem_req_valid), 0);
    check("dcw ic_rd held",  ic_rd_data, 32'hCCCC_0003);
    check("dcw ic_cnt held", 32'(ic_done_cnt), 2);
    dc_req_valid  = 1'b0;
    mem_req_ready = 1'b0;
    tick();
    check("dcw pulse end",   32'(dc_req_ready), 0);
    check("dcw rd held",     dc_rd_data, 32'h0BAD_0000);
    check("dcw cnt held",    32'(dc_done_cnt), 2);

    // Reset while BUSY_IC with memory answering in the same cycle.
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_0700;
    tick();
    check("rmid grant", 32'(mem_req_valid), 1);
    rst           = 1'b1;
    mem_req_ready = 1'b1;
    mem_req_data  = 32'h0000_7777;
    tick();
    check("rmid valid", 32'(mem_req_valid), 0);
    check("rmid ready", 32'(ic_req_ready), 0);
    check("rmid cnt",   32'(ic_done_cnt), 0);
    check("rmid rd",    ic_rd_data, 0);
    rst           = 1'b0;
    mem_req_ready = 1'b0;
    tick();
    check("rmid regrant valid", 32'(mem_req_valid), 1);
    check("rmid regrant addr",  mem_req_addr, 32'h0000_0700);
    mem_req_ready = 1'b1;
    mem_req_data  = 32'h7070_7070;
    tick();
    check("rmid serve ready", 32'(ic_req_ready), 1);
    check("rmid serve rd",    ic_rd_data, 32'h7070_7070);
    check("rmid serve cnt",   32'(ic_done_cnt), 1);
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b0;
    tick();
    check("rmid pulse end", 32'(ic_req_ready), 0);

    // Saturation: both requesting continuously, memory answers with k=1.
    do_reset();
    n_g     = 0;
    prev_mv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      g_addr[i] = '0;
      g_cyc[i]  = 0;
    end
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_0300;
    dc_req_valid = 1'b1;
    dc_req_addr  = 32'h0000_0400;
    dc_req_wr    = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (mem_req_valid && !prev_mv && n_g < 6) begin
        g_addr[n_g] = mem_req_addr;
        g_cyc[n_g]  = c;
        n_g++;
      end
      prev_mv       = mem_req_valid;
      mem_req_ready = mem_req_valid;
      mem_req_data  = 32'h5000_0000 + 32'(c);
      if (n_g == 6) begin
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
      end
    end
    mem_req_ready = 1'b0;
    check("sat grants", 32'(n_g), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("sat order%0d", i), g_addr[i], (i % 2 == 0) ? 32'h0000_0300 : 32'h0000_0400);
      if (i > 0)
        check($sformatf("sat spacing%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 3);
    end
    check("sat ic_cnt", 32'(ic_done_cnt), 3);
    check("sat dc_cnt", 32'(dc_done_cnt), 3);

    // Counter wrap with a 4-bit counter over 17 IC transactions.
    do_reset();
    for (int t = 1; t <= 17; t++) begin
      ic_req_valid = 1'b1;
      ic_req_addr  = 32'(t);
      tick();
      mem_req_ready = 1'b1;
      mem_req_data  = 32'(t);
      tick();
      if (t >= 15) begin
        check($sformatf("wrap t%0d ready", t), 32'(ic_req_ready), 1);
        check($sformatf("wrap t%0d cnt", t),   32'(ic_done_cnt), 32'(t % 16));
      end
      ic_req_valid  = 1'b0;
      mem_req_ready = 1'b0;
      tick();
    end
    check("wrap dc_cnt untouched", 32'(dc_done_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
